// File: rtl/adder_bist.sv
// -----------------------------------------------------------------------------
// adder_bist
//
// Built-in self-test engine for a WIDTH-bit combinational adder with carry-in
// and carry-out. Every {A, B, Cin} combination is applied in ascending order.
// Each vector is held for SETTLE cycles, then {Cout, Sum} is sampled and
// compared against a golden A+B+Cin. The engine reports a mismatch count, the
// first failing vector with its observed result, and a pass flag.
//
// Parameters
//   WIDTH   operand width of the adder under test
//   SETTLE  cycles a vector is held before it is sampled (1..15)
//
// Ports
//   clk               system clock, all state on the rising edge
//   rst_n             asynchronous active-low reset
//   start             single-cycle pulse, begins a full sweep
//   dut_a/dut_b       operands to the adder under test
//   dut_cin           carry-in to the adder under test
//   dut_sum/dut_cout  result returned by the adder under test
//   busy              high while a sweep is in progress
//   done              high from sweep completion until the next accepted start
//   pass              high with done when no mismatch was seen
//   err_cnt           number of mismatching vectors in the last sweep
//   first_fail_valid  a mismatch has been captured in this sweep
//   first_fail_vec    {A,B,Cin} of the first mismatch
//   first_fail_obs    {Cout,Sum} observed at the first mismatch
// -----------------------------------------------------------------------------
module adder_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   output logic                 dut_cin,
   input  logic [WIDTH-1:0]     dut_sum,
   input  logic                 dut_cout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   err_cnt,
   output logic                 first_fail_valid,
   output logic [2*WIDTH:0]     first_fail_vec,
   output logic [WIDTH:0]       first_fail_obs
);

   localparam int VEC_W = 2*WIDTH + 1;
   localparam int ERR_W = 2*WIDTH + 2;   // holds 2^VEC_W, so it never wraps
   localparam int OBS_W = WIDTH + 1;

   // Settle counter is 4 bits wide, enough for the full 1..15 SETTLE range.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q,  state_d;
   logic [VEC_W-1:0]   vec_q,    vec_d;
   logic [3:0]         settle_q, settle_d;
   logic [ERR_W-1:0]   err_q,    err_d;
   logic               ffv_q,    ffv_d;
   logic [VEC_W-1:0]   ffvec_q,  ffvec_d;
   logic [OBS_W-1:0]   ffobs_q,  ffobs_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic               pass_q,   pass_d;

   logic [OBS_W-1:0]   golden;
   logic [OBS_W-1:0]   observed;
   logic               mismatch;

   // Operands come straight from the vector register.
   assign dut_a   = vec_q[2*WIDTH:WIDTH+1];
   assign dut_b   = vec_q[WIDTH:1];
   assign dut_cin = vec_q[0];

   assign golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
   assign observed = {dut_cout, dut_sum};
   // Case-inequality so that X/Z coming back from the adder counts as a failure.
   assign mismatch = (observed !== golden);

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      err_d    = err_q;
      ffv_d    = ffv_q;
      ffvec_d  = ffvec_q;
      ffobs_d  = ffobs_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;

      case (state_q)
         IDLE, DONE: begin
            // A start in DONE restarts exactly as from IDLE.
            if (start) begin
               vec_d    = '0;
               settle_d = '0;
               err_d    = '0;
               ffv_d    = 1'b0;
               ffvec_d  = '0;
               ffobs_d  = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               state_d  = WAIT;
            end
         end

         WAIT: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == SETTLE_LAST) begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
               if (!ffv_q) begin
                  ffv_d   = 1'b1;
                  ffvec_d = vec_q;
                  ffobs_d = observed;
               end
            end
            if (&vec_q) begin
               // pass is taken from the count including this last vector.
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               state_d = DONE;
            end else begin
               vec_d    = vec_q + VEC_W'(1);
               settle_d = '0;
               state_d  = WAIT;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         err_q    <= '0;
         ffv_q    <= 1'b0;
         ffvec_q  <= '0;
         ffobs_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         ffv_q    <= ffv_d;
         ffvec_q  <= ffvec_d;
         ffobs_q  <= ffobs_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_cnt          = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
   assign first_fail_obs   = ffobs_q;

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
Hardware built-in self-test engine for a WIDTH-bit combinational adder with carry-in and carry-out (e.g. a ripple-carry adder) running on the FPGA board.
- Drives every {A, B, Cin} combination into the adder under test.
- Waits a programmable settle time, then samples {Cout, Sum} and compares it against a golden A+B+Cin.
- Reports an error count, the first failing vector and a pass flag, which can be mapped to LEDs / 7-segment.

Parameters:
WIDTH, 4, operand width of the adder under test.
SETTLE, 1, cycles the vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a full sweep
dut_a  output  WIDTH  operand A to adder under test
dut_b  output  WIDTH  operand B to adder under test
dut_cin  output  1  carry-in to adder under test
dut_sum  input  WIDTH  sum returned by adder under test
dut_cout  input  1  carry-out returned by adder under test
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until the next accepted start
pass  output  1  high with done when err_cnt == 0
err_cnt  output  2*WIDTH+2  number of mismatching vectors in the last sweep
first_fail_valid  output  1  a mismatch has been captured in this sweep
first_fail_vec  output  2*WIDTH+1  {A,B,Cin} of the first mismatch
first_fail_obs  output  WIDTH+1  {Cout,Sum} observed at the first mismatch

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (any time, including mid-sweep): state IDLE.
  - All outputs and internal registers go to 0, including the vector register and the settle counter.
- Vector register vec, 2*WIDTH+1 bits: dut_a = vec[2W:W+1], dut_b = vec[W:1], dut_cin = vec[0].
  - The dut_* outputs are driven directly from vec, with no extra logic.
  - Sweep order is vec = 0, 1, ..., 2^(2W+1)-1, ascending.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE: on start=1, clear vec, err_cnt, first_fail_*, done and pass. Set busy=1, settle counter=0, go to WAIT.
- WAIT: settle counter increments each cycle. When it equals SETTLE-1, go to CHECK.
- CHECK (one cycle):
  - golden = zero-extended dut_a + dut_b + dut_cin, WIDTH+1 bits.
  - If {dut_cout,dut_sum} != golden: err_cnt += 1.
  - If first_fail_valid==0 at that mismatch: latch vec into first_fail_vec and {dut_cout,dut_sum} into first_fail_obs, and set first_fail_valid.
  - If vec is all-ones: go to DONE. Otherwise vec += 1, reset the settle counter, go to WAIT.
- DONE (entered on the edge after the last CHECK):
  - busy=0, done=1, pass = (err_cnt==0), both registered.
  - Results hold.
  - start=1 restarts exactly as from IDLE.
- Per-vector cost is SETTLE+1 cycles. With the defaults, done rises 512*2 = 1024 cycles after the start edge.
- start while busy is ignored and the sweep is unaffected.
- A start coincident with reset deassertion is ignored if rst_n is low at that edge.
- err_cnt width holds the full vector count (2^(2W+1)), so no saturation or wrap is possible.
- Sampled DUT inputs are compared only in CHECK; values in WAIT are don't-care.
- X/Z on dut_sum or dut_cout counts as a mismatch in simulation. The compare must use the case-inequality operator.

Test Plan:
- Correct behavioural adder attached, defaults, start pulse:
  - busy rises next edge; done=1 exactly 1024 cycles after start.
  - err_cnt=0, pass=1, first_fail_valid=0.
- dut_cout stuck at 0:
  - err_cnt=256, pass=0.
  - first_fail_vec=9'h01F (A=0, B=15, Cin=1), first_fail_obs=5'h00.
- dut_sum[0] stuck at 0:
  - err_cnt=256.
  - first_fail_vec=9'h001, first_fail_obs=5'h00.
- SETTLE=3 with correct adder:
  - Each vector is held 4 cycles; done at 2048 cycles; pass=1.
- Assert rst_n=0 at vec=100 mid-sweep:
  - All outputs are 0 immediately (asynchronously).
  - After release, the block idles until start; a new sweep from vec=0 completes with pass=1.
- Second start pulse at cycle 300 of a sweep:
  - Ignored; done still at cycle 1024.
  - A start in DONE clears done/pass/err_cnt the next edge and re-runs the sweep.
